matvec_seq_ctrl: RTL and testbench
==================================

# matvec_seq_ctrl

Sequencer for the AXI-Stream matrix–vector coprocessor. It accepts A (ROWS×COLS, row-major) and then B (COLS) over the slave stream and writes them into A_RAM and B_RAM. It then computes RES[r] = sat((Σ A[r][c]·B[c]) >> SHIFT) into RES_RAM and streams RES out over the master stream. It owns every RAM port; the RAMs themselves stay external.

## Interface
- ROWS, 2, rows of A and length of RES
- COLS, 4, columns of A and length of B
- WIDTH, 8, element width; lower WIDTH bits of a stream word
- SHIFT, 8, right shift applied to the accumulator before saturation
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- S_AXIS_TREADY  out  1  slave ready
- S_AXIS_TDATA  in  32  slave data; bits [WIDTH-1:0] used
- S_AXIS_TLAST  in  1  ignored; framing is by count
- S_AXIS_TVALID  in  1  slave valid
- M_AXIS_TVALID  out  1  master valid
- M_AXIS_TDATA  out  32  {zeros, RES word}
- M_AXIS_TLAST  out  1  high on RES[ROWS-1]
- M_AXIS_TREADY  in  1  master ready
- RAM_WDATA  out  WIDTH  shared write data to all three RAMs
- A_ADDR / A_WEN  out  clog2(ROWS*COLS) / 1  A_RAM address, write enable
- A_RDATA  in  WIDTH  A_RAM read data, sync read, 1-cycle latency
- B_ADDR / B_WEN  out  clog2(COLS) / 1  B_RAM address, write enable
- B_RDATA  in  WIDTH  B_RAM read data, 1-cycle latency
- R_ADDR / R_WEN  out  clog2(ROWS) / 1  RES_RAM address, write enable
- R_RDATA  in  WIDTH  RES_RAM read data, 1-cycle latency
- STATE  out  4  current state encoding, for debug

## Operation
- States: IDLE(0) → RECV_A(1) → RECV_B(2) → MAC(3) → WRITE(4) → FETCH(5) → SEND(6) → IDLE.
- IDLE: TREADY=1. The first handshake is written to A_RAM[0] and moves the FSM to RECV_A. The IDLE/RECV_A pair writes A_RAM[0..ROWS*COLS-1] in order, one word per handshake.
- RECV_B: TREADY=1. Each handshake k writes B_RAM[k]. After handshake COLS-1 the FSM moves to MAC with row r=0 and acc=0.
- MAC: COLS cycles. Cycle k issues A_ADDR=r*COLS+k and B_ADDR=k. On the following edge, acc += A_RDATA·B_RDATA from the read issued one cycle earlier. One drain cycle absorbs the final product.
- Accumulator width: 2·WIDTH+clog2(COLS), unsigned.
- WRITE: one cycle. R_ADDR=r, R_WEN=1, RAM_WDATA = min(acc>>SHIFT, 2^WIDTH−1). acc clears. If r<ROWS-1, r increments and the FSM returns to MAC. Otherwise it goes to FETCH with j=0.
- FETCH: R_ADDR=j for one cycle, then SEND.
- SEND: TVALID=1, TDATA={0,R_RDATA} registered, TLAST=(j==ROWS-1). TDATA, TLAST and TVALID hold until TREADY. On handshake: if j<ROWS-1, j increments and the FSM goes to FETCH; otherwise it goes to IDLE.
- S_AXIS_TREADY=0 in every state except IDLE, RECV_A and RECV_B.

## Timing
- Reset (async assert, sync deassert in the platform): STATE=IDLE, all counters and acc=0, all WEN=0, TVALID=0, TLAST=0, TDATA=0, S_AXIS_TREADY=0 while ARESETN=0.
- Reset mid-frame returns to IDLE. RAM contents are not cleared. The next frame starts at A[0].
- Receive: one word per cycle at full rate. TVALID gaps stall counters with no side effects.
- Compute latency per row: COLS+1 cycles in MAC plus 1 in WRITE. With defaults: 12 cycles from the last B handshake to the first FETCH.
- Send: 2 cycles per word minimum. TREADY low holds all master outputs stable (AXIS rule). TVALID never drops without a handshake.
- WEN pulses are exactly one cycle per accepted or computed word. No RAM is ever read and written at the same address in the same cycle.

## Structure
- Package matvec_pkg: state enum with fixed 4-bit encodings, default ROWS/COLS/WIDTH/SHIFT, and an ACC_W localparam function.
- One sub-module, matvec_mac: a registered multiply-accumulate with clear and enable inputs, instantiated once.

## Test plan
- SHIFT=0, A=1..8, B=1,1,1,1 → RES_RAM={10,26}. Output stream is 0x0A then 0x1A with TLAST on the second word.
- Defaults, A row0=0x10×4, row1=0x80×4, B=0x10×4 and then 0x80×4 in a second frame. Frame 1 → {0x04,0x20}. Frame 2 with B=0x80 → row1 sum 65536>>8=256, saturates to 0xFF.
- Random TVALID gaps on the slave and random TREADY stalls on the master → same results. Master TDATA/TLAST stable while stalled. S_AXIS_TREADY=0 during MAC, WRITE, FETCH and SEND.
- ARESETN pulsed after 5 A beats, then a full clean frame → correct results and no stale writes. STATE=0 and all outputs 0 during reset.
- Two back-to-back frames with TREADY held high → second frame accepted in IDLE immediately after the first frame's TLAST handshake, with correct results for both.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared types and sizing helpers for the matrix-vector sequencer.
package matvec_pkg;

    // Fixed encodings are visible on the STATE debug port.
    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StRecvA = 4'd1,
        StRecvB = 4'd2,
        StMac   = 4'd3,
        StWrite = 4'd4,
        StFetch = 4'd5,
        StSend  = 4'd6
    } state_e;

    localparam int unsigned DEF_ROWS  = 2;
    localparam int unsigned DEF_COLS  = 4;
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_SHIFT = 8;

    // Unsigned accumulator wide enough for COLS full-scale products.
    function automatic int unsigned acc_w(input int unsigned width, input int unsigned cols);
        return 2 * width + $clog2(cols);
    endfunction

    // Address width for n entries, never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matvec_mac.sv
// Registered multiply-accumulate with synchronous clear (clear wins over enable).
module matvec_mac
    import matvec_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ACC_W = acc_w(DEF_WIDTH, DEF_COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [ACC_W-1:0] acc
);

    logic [2*WIDTH-1:0] prod;

    // Full-width product of the two RAM read words.
    always_comb begin
        prod = a * b;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/matvec_seq_ctrl.sv
// Sequencer for the AXI-Stream matrix-vector coprocessor: loads A and B into external
// RAMs, computes saturated row dot products into RES_RAM, then streams RES out.
module matvec_seq_ctrl
    import matvec_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SHIFT = DEF_SHIFT
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    output logic                             S_AXIS_TREADY,
    input  logic [31:0]                      S_AXIS_TDATA,
    input  logic                             S_AXIS_TLAST,
    input  logic                             S_AXIS_TVALID,
    output logic                             M_AXIS_TVALID,
    output logic [31:0]                      M_AXIS_TDATA,
    output logic                             M_AXIS_TLAST,
    input  logic                             M_AXIS_TREADY,
    output logic [WIDTH-1:0]                 RAM_WDATA,
    output logic [addr_w(ROWS*COLS)-1:0]     A_ADDR,
    output logic                             A_WEN,
    input  logic [WIDTH-1:0]                 A_RDATA,
    output logic [addr_w(COLS)-1:0]          B_ADDR,
    output logic                             B_WEN,
    input  logic [WIDTH-1:0]                 B_RDATA,
    output logic [addr_w(ROWS)-1:0]          R_ADDR,
    output logic                             R_WEN,
    input  logic [WIDTH-1:0]                 R_RDATA,
    output logic [3:0]                       STATE
);

    localparam int unsigned AW    = addr_w(ROWS * COLS);
    localparam int unsigned BW    = addr_w(COLS);
    localparam int unsigned RW    = addr_w(ROWS);
    localparam int unsigned KW    = addr_w(COLS + 1);
    localparam int unsigned ACC_W = acc_w(WIDTH, COLS);

    localparam logic [AW-1:0] A_LAST = AW'(ROWS * COLS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(COLS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(COLS);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

    state_e           state_q;
    logic [AW-1:0]    a_cnt_q;
    logic [BW-1:0]    b_cnt_q;
    logic [KW-1:0]    k_q;
    logic [RW-1:0]    r_q;
    logic [RW-1:0]    j_q;
    logic             tready_q;
    logic             tvalid_q;
    logic             tlast_q;

    logic             rx_hs;
    logic             mac_en;
    logic             mac_clr;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] shifted;
    logic [WIDTH-1:0] sat;
    logic [AW-1:0]    row_base;

    // Framing is by count, so TLAST and the upper data bits are intentionally dropped.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXIS_TLAST, S_AXIS_TDATA[31:WIDTH]};

    assign rx_hs         = S_AXIS_TVALID & tready_q;
    assign S_AXIS_TREADY = tready_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign STATE         = state_q;

    // MAC cycle 0 only issues the first read; cycles 1..COLS absorb the returned products.
    assign mac_en  = (state_q == StMac) && (k_q != '0);
    assign mac_clr = (state_q == StWrite) || (state_q == StIdle);

    matvec_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (A_RDATA),
        .b     (B_RDATA),
        .acc   (acc)
    );

    // Scale the accumulator and clamp to the element range.
    always_comb begin
        shifted  = acc >> SHIFT;
        sat      = (|shifted[ACC_W-1:WIDTH]) ? '1 : shifted[WIDTH-1:0];
        row_base = AW'(r_q * COLS);
    end

    // RAM port steering; writes are qualified by the live handshake so none is delayed.
    always_comb begin
        A_ADDR    = a_cnt_q;
        B_ADDR    = b_cnt_q;
        R_ADDR    = j_q;
        A_WEN     = 1'b0;
        B_WEN     = 1'b0;
        R_WEN     = 1'b0;
        RAM_WDATA = '0;
        case (state_q)
            StIdle, StRecvA: begin
                A_WEN = rx_hs;
                if (rx_hs) RAM_WDATA = S_AXIS_TDATA[WIDTH-1:0];
            end
            StRecvB: begin
                B_WEN = rx_hs;
                if (rx_hs) RAM_WDATA = S_AXIS_TDATA[WIDTH-1:0];
            end
            StMac: begin
                A_ADDR = row_base + AW'(k_q);
                B_ADDR = k_q[BW-1:0];
            end
            StWrite: begin
                R_ADDR    = r_q;
                R_WEN     = 1'b1;
                RAM_WDATA = sat;
            end
            default: ;
        endcase
    end

    // R_ADDR stays on j through SEND, so the RAM read register holds TDATA stable.
    always_comb begin
        M_AXIS_TDATA = (state_q == StSend) ? 32'(R_RDATA) : '0;
    end

    // Main sequencer FSM with registered handshake outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= StIdle;
            a_cnt_q  <= '0;
            b_cnt_q  <= '0;
            k_q      <= '0;
            r_q      <= '0;
            j_q      <= '0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StRecvA: begin
                    tready_q <= 1'b1;
                    if (rx_hs) begin
                        if (a_cnt_q == A_LAST) begin
                            a_cnt_q <= '0;
                            state_q <= StRecvB;
                        end else begin
                            a_cnt_q <= a_cnt_q + 1'b1;
                            state_q <= StRecvA;
                        end
                    end
                end
                StRecvB: begin
                    if (rx_hs) begin
                        if (b_cnt_q == B_LAST) begin
                            b_cnt_q  <= '0;
                            r_q      <= '0;
                            k_q      <= '0;
                            tready_q <= 1'b0;
                            state_q  <= StMac;
                        end else begin
                            b_cnt_q <= b_cnt_q + 1'b1;
                        end
                    end
                end
                StMac: begin
                    if (k_q == K_LAST) begin
                        k_q     <= '0;
                        state_q <= StWrite;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StWrite: begin
                    if (r_q == R_LAST) begin
                        r_q     <= '0;
                        j_q     <= '0;
                        state_q <= StFetch;
                    end else begin
                        r_q     <= r_q + 1'b1;
                        state_q <= StMac;
                    end
                end
                StFetch: begin
                    tvalid_q <= 1'b1;
                    tlast_q  <= (j_q == R_LAST);
                    state_q  <= StSend;
                end
                StSend: begin
                    if (M_AXIS_TREADY) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        if (j_q == R_LAST) begin
                            j_q      <= '0;
                            tready_q <= 1'b1;
                            state_q  <= StIdle;
                        end else begin
                            j_q     <= j_q + 1'b1;
                            state_q <= StFetch;
                        end
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    tready_q <= 1'b0;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_seq_ctrl.sv
// Directed bench: two sequencers (SHIFT=0 and SHIFT=8) share one stimulus stream.
module tb_matvec_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        m_tready;

    logic [1:0]       s_tready;
    logic [1:0]       m_tvalid;
    logic [1:0]       m_tlast;
    logic [1:0]       a_wen;
    logic [1:0]       b_wen;
    logic [1:0]       r_wen;
    logic [1:0][31:0] m_tdata;
    logic [1:0][3:0]  state;

    int checks   = 0;
    int failures = 0;

    logic [7:0] a_vec [8];
    logic [7:0] b_vec [4];

    // Index 0 runs with SHIFT=0, index 1 with SHIFT=8; each has its own RAM models.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned SH = (g == 0) ? 0 : 8;
        logic [7:0] wdata;
        logic [7:0] a_rd;
        logic [7:0] b_rd;
        logic [7:0] r_rd;
        logic [2:0] a_addr;
        logic [1:0] b_addr;
        logic [0:0] r_addr;
        logic [7:0] a_mem [8];
        logic [7:0] b_mem [4];
        logic [7:0] r_mem [2];

        matvec_seq_ctrl #(
            .ROWS  (2),
            .COLS  (4),
            .WIDTH (8),
            .SHIFT (SH)
        ) u_dut (
            .ACLK          (clk),
            .ARESETN       (rst_n),
            .S_AXIS_TREADY (s_tready[g]),
            .S_AXIS_TDATA  (s_tdata),
            .S_AXIS_TLAST  (s_tlast),
            .S_AXIS_TVALID (s_tvalid),
            .M_AXIS_TVALID (m_tvalid[g]),
            .M_AXIS_TDATA  (m_tdata[g]),
            .M_AXIS_TLAST  (m_tlast[g]),
            .M_AXIS_TREADY (m_tready),
            .RAM_WDATA     (wdata),
            .A_ADDR        (a_addr),
            .A_WEN         (a_wen[g]),
            .A_RDATA       (a_rd),
            .B_ADDR        (b_addr),
            .B_WEN         (b_wen[g]),
            .B_RDATA       (b_rd),
            .R_ADDR        (r_addr),
            .R_WEN         (r_wen[g]),
            .R_RDATA       (r_rd),
            .STATE         (state[g])
        );

        // Synchronous-read RAMs with one cycle of read latency.
        always @(posedge clk) begin
            if (a_wen[g]) a_mem[a_addr] <= wdata;
            if (b_wen[g]) b_mem[b_addr] <= wdata;
            if (r_wen[g]) r_mem[r_addr] <= wdata;
            a_rd <= a_mem[a_addr];
            b_rd <= b_mem[b_addr];
            r_rd <= r_mem[r_addr];
        end
    end

    task automatic push_word(input logic [7:0] w, input int gap);
        int cnt;
        s_tvalid = 1'b0;
        repeat (gap) @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = {24'hA5C3_00, w} | 32'h5A00_0000;
        cnt = 0;
        while (!s_tready[0] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!s_tready[0]) begin
            checks++;
            failures++;
            $display("FAIL push_timeout s_tready=%b required=1", s_tready[0]);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        int cyc;
        int bad;
        for (int i = 0; i < 8; i++) begin
            push_word(a_vec[i], gaps ? int'($urandom_range(0, 2)) : 0);
            if (i == 0) begin
                checks++;
                if (state[0] !== 4'd1) begin
                    failures++;
                    $display("FAIL state_after_first_a got=%0d required=1", state[0]);
                end
            end
        end
        for (int i = 0; i < 4; i++) push_word(b_vec[i], gaps ? int'($urandom_range(0, 2)) : 0);
        checks++;
        if (state !== {4'd3, 4'd3} || s_tready !== 2'b00) begin
            failures++;
            $display("FAIL enter_mac state=%h s_tready=%b required=33/00", state, s_tready);
        end
        cyc = 0;
        bad = 0;
        while (state[0] !== 4'd5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (s_tready !== 2'b00) bad++;
        end
        checks++;
        if (cyc != 12) begin
            failures++;
            $display("FAIL compute_latency got=%0d required=12", cyc);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL s_tready_during_compute high_cycles=%0d required=0", bad);
        end
    endtask

    task automatic recv_frame(input logic [7:0] e00, input logic [7:0] e01,
                              input logic [7:0] e80, input logic [7:0] e81,
                              input bit rand_stall, input bit hold);
        int cnt;
        int stall;
        logic [7:0] e0;
        logic [7:0] e8;
        logic       el;
        for (int i = 0; i < 2; i++) begin
            e0 = (i == 0) ? e00 : e01;
            e8 = (i == 0) ? e80 : e81;
            el = (i == 1);
            m_tready = hold;
            cnt = 0;
            while (!m_tvalid[0] && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (m_tvalid !== 2'b11) begin
                failures++;
                $display("FAIL m_tvalid_wait word=%0d got=%b required=11", i, m_tvalid);
            end
            checks++;
            if (m_tdata[0] !== {24'h0, e0} || m_tdata[1] !== {24'h0, e8}) begin
                failures++;
                $display("FAIL m_tdata word=%0d got=%h/%h required=%h/%h",
                         i, m_tdata[0], m_tdata[1], e0, e8);
            end
            checks++;
            if (m_tlast !== {el, el} || state[0] !== 4'd6 || s_tready !== 2'b00) begin
                failures++;
                $display("FAIL send_flags word=%0d tlast=%b state=%0d s_tready=%b required=%b/6/00",
                         i, m_tlast, state[0], s_tready, {el, el});
            end
            stall = (rand_stall && !hold) ? int'($urandom_range(1, 4)) : 0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                checks++;
                if ({m_tvalid, m_tlast, m_tdata[0], m_tdata[1]} !==
                    {2'b11, el, el, {24'h0, e0}, {24'h0, e8}}) begin
                    failures++;
                    $display("FAIL stall_hold word=%0d v=%b l=%b d=%h/%h required=11/%b/%h/%h",
                             i, m_tvalid, m_tlast, m_tdata[0], m_tdata[1], el, e0, e8);
                end
            end
            m_tready = 1'b1;
            @(negedge clk);
            m_tready = hold;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (state !== 8'h00 || s_tready !== 2'b00 || m_tvalid !== 2'b00 || m_tlast !== 2'b00 ||
            m_tdata !== 64'h0 || (a_wen | b_wen | r_wen) !== 2'b00) begin
            failures++;
            $display("FAIL %s state=%h s_tready=%b m_tvalid=%b m_tlast=%b m_tdata=%h wen=%b required all 0",
                     tag, state, s_tready, m_tvalid, m_tlast, m_tdata, a_wen | b_wen | r_wen);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 2'b11 || state !== 8'h00) begin
            failures++;
            $display("FAIL idle_ready s_tready=%b state=%h required=11/00", s_tready, state);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) a_vec[i] = 8'(i + 1);
        for (int i = 0; i < 4; i++) b_vec[i] = 8'd1;
        send_frame(1'b0);
        recv_frame(8'h0A, 8'h1A, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            a_vec[i]     = 8'h10;
            a_vec[i + 4] = 8'h80;
            b_vec[i]     = 8'h10;
        end
        m_tready = 1'b1;
        send_frame(1'b0);
        recv_frame(8'hFF, 8'hFF, 8'h04, 8'h20, 1'b0, 1'b1);
        checks++;
        if (state !== 8'h00 || s_tready !== 2'b11) begin
            failures++;
            $display("FAIL idle_after_tlast state=%h s_tready=%b required=00/11", state, s_tready);
        end
        for (int i = 0; i < 4; i++) b_vec[i] = 8'h80;
        send_frame(1'b0);
        recv_frame(8'hFF, 8'hFF, 8'h20, 8'hFF, 1'b0, 1'b1);
        m_tready = 1'b0;
    endtask

    task automatic test_stalls();
        a_vec = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd200, 8'd100, 8'd50, 8'd25};
        b_vec = '{8'd2, 8'd4, 8'd6, 8'd8};
        send_frame(1'b1);
        recv_frame(8'h8C, 8'hFF, 8'h00, 8'h05, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 5; i++) push_word(8'h77, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        @(negedge clk);
        check_reset_outputs("reset_mid_frame");
        rst_n = 1'b1;
        @(negedge clk);
        a_vec = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        b_vec = '{8'd1, 8'd2, 8'd3, 8'd4};
        send_frame(1'b0);
        recv_frame(8'h3C, 8'h14, 8'h00, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stalls();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time_limit reached");
        $fatal(1, "watchdog");
    end

endmodule
